// File: rtl/uart_byte_rx.sv
// 16x oversampling UART receiver: 8N1, or 8E1 when PARITY_EN=1, on a 50 MHz clock.
// Delivers the byte with a one-cycle Rx_Done strobe plus parity and framing flags.
module uart_byte_rx #(
    parameter int PARITY_EN = 1,
    parameter int CLK_HZ    = 50000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // The divisor table below is hand-computed for a 50 MHz clock.
    if (CLK_HZ != 50000000) begin : g_clk_hz_note
    end

    logic       rx_s1, rx_s2, rx_s3;
    logic [2:0] fsm;
    logic [2:0] baud_q;
    logic [8:0] div_cnt;
    logic [8:0] div_max;
    logic [3:0] tick_idx;
    logic [2:0] bit_idx;
    logic       smp7, smp8;
    logic [7:0] shreg;
    logic       par_acc;
    logic       par_bad;
    logic       stop_bit;
    logic       running;
    logic       tick;
    logic       decide;
    logic       boundary;
    logic       maj;
    logic       fall;

    always_comb begin
        case (baud_q)
            3'd1:    div_max = 9'd162;
            3'd2:    div_max = 9'd80;
            3'd3:    div_max = 9'd53;
            3'd4:    div_max = 9'd26;
            default: div_max = 9'd324;
        endcase
    end

    assign running  = (fsm != S_IDLE) && (fsm != S_DONE);
    assign tick     = running && (div_cnt == div_max);
    assign decide   = tick && (tick_idx == 4'd9);
    assign boundary = tick && (tick_idx == 4'd15);
    // Tick 9 sample is taken live so the decision lands on the same tick.
    assign maj      = (smp7 & smp8) | (smp7 & rx_s2) | (smp8 & rx_s2);
    assign fall     = rx_s3 & ~rx_s2;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= Rs232_Rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt  <= 9'd0;
            tick_idx <= 4'd0;
            smp7     <= 1'b0;
            smp8     <= 1'b0;
        end else if (!running) begin
            div_cnt  <= 9'd0;
            tick_idx <= 4'd0;
        end else begin
            div_cnt <= tick ? 9'd0 : div_cnt + 9'd1;
            if (tick) begin
                tick_idx <= tick_idx + 4'd1;
                if (tick_idx == 4'd7) smp7 <= rx_s2;
                if (tick_idx == 4'd8) smp8 <= rx_s2;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fsm        <= S_IDLE;
            baud_q     <= 3'd0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            stop_bit   <= 1'b1;
            data_byte  <= 8'd0;
            Rx_Done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            state      <= 1'b0;
        end else begin
            Rx_Done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (fall) begin
                        baud_q <= baud_set;
                        state  <= 1'b1;
                        fsm    <= S_START;
                    end
                end
                S_START: begin
                    if (decide && maj) begin
                        // Line went back high: a glitch, not a start bit.
                        fsm   <= S_IDLE;
                        state <= 1'b0;
                    end else if (boundary) begin
                        bit_idx <= 3'd0;
                        par_acc <= 1'b0;
                        fsm     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[7:1]};
                        par_acc <= par_acc ^ maj;
                    end
                    if (boundary) begin
                        if (bit_idx == 3'd7)
                            fsm <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (decide) par_bad <= par_acc ^ maj;
                    if (boundary) fsm <= S_STOP;
                end
                S_STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (decide) begin
                        stop_bit <= maj;
                        fsm      <= S_DONE;
                    end
                end
                S_DONE: begin
                    data_byte  <= shreg;
                    parity_err <= (PARITY_EN != 0) ? par_bad : 1'b0;
                    frame_err  <= ~stop_bit;
                    Rx_Done    <= 1'b1;
                    state      <= 1'b0;
                    fsm        <= S_IDLE;
                end
                default: begin
                    fsm   <= S_IDLE;
                    state <= 1'b0;
                end
            endcase
        end
    end

endmodule
